// File: rtl/hs_pkg.sv
// Shared types and payload helpers for the handshake burst master.
// HS_BURST_MASTER_LFSR_EN selects the Galois LFSR payload instead of the counter.
package hs_pkg;

  localparam int HS_DEF_WIDTH = 8;
  localparam int HS_DEF_LEN_W = 8;
  localparam int HS_MAX_W     = 32;

  typedef enum logic [0:0] {
    HS_IDLE = 1'b0,
    HS_SEND = 1'b1
  } hs_state_t;

  typedef logic [HS_MAX_W-1:0] hs_word_t;

  function automatic hs_word_t hs_mask(input int width);
    hs_word_t m;
    m = '0;
    for (int i = 0; i < HS_MAX_W; i++) begin
      if (i < width) m[i] = 1'b1;
    end
    return m;
  endfunction

  // An all-zero LFSR state never leaves zero, so the seed is nudged to 1 there.
  function automatic hs_word_t hs_seed_fix(input hs_word_t seed, input int width);
    hs_word_t s;
    s = seed & hs_mask(width);
`ifdef HS_BURST_MASTER_LFSR_EN
    if (s == '0) s = hs_word_t'(1);
`endif
    return s;
  endfunction

  function automatic hs_word_t hs_next_payload(input hs_word_t cur, input int width,
                                               input hs_word_t step, input hs_word_t poly);
    hs_word_t nxt;
`ifdef HS_BURST_MASTER_LFSR_EN
    nxt = cur << 1;
    if (cur[width-1]) nxt = nxt ^ poly;
`else
    nxt = cur + step;
`endif
    return nxt & hs_mask(width);
  endfunction

endpackage

// File: rtl/hs_pattern_gen.sv
// Payload generator: holds the payload of the beat that follows the one on the bus.
// Counter or LFSR stepping is chosen by HS_BURST_MASTER_LFSR_EN (see hs_pkg).
module hs_pattern_gen
  import hs_pkg::*;
#(
  parameter int          WIDTH = HS_DEF_WIDTH,
  parameter int unsigned SEED  = 'h01,
  parameter int unsigned STEP  = 'h01,
  parameter int unsigned POLY  = 'hB8
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             load_seed,
  input  logic             advance,
  output logic [WIDTH-1:0] payload
);

  localparam hs_word_t         SEED_FIX  = hs_seed_fix(hs_word_t'(SEED), WIDTH);
  localparam logic [WIDTH-1:0] SEED_W    = WIDTH'(SEED_FIX);
  localparam logic [WIDTH-1:0] SEED_NEXT = WIDTH'(hs_next_payload(SEED_FIX, WIDTH,
                                                   hs_word_t'(STEP), hs_word_t'(POLY)));

  logic [WIDTH-1:0] payload_reg;
  logic [WIDTH-1:0] payload_next;

  assign payload_next = WIDTH'(hs_next_payload(hs_word_t'(payload_reg), WIDTH,
                                               hs_word_t'(STEP), hs_word_t'(POLY)));

  // The seed itself goes straight onto the bus, so a reload queues its successor.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      payload_reg <= SEED_W;
    end else if (load_seed) begin
      payload_reg <= SEED_NEXT;
    end else if (advance) begin
      payload_reg <= payload_next;
    end
  end

  assign payload = payload_reg;

endmodule

// File: rtl/hs_burst_master.sv
// Valid/ready burst source: FSM, beat index and registered bus outputs.
// Define HS_BURST_MASTER_LFSR_EN for an LFSR payload; otherwise payload counts by STEP.
module hs_burst_master
  import hs_pkg::*;
#(
  parameter int          WIDTH = HS_DEF_WIDTH,
  parameter int          LEN_W = HS_DEF_LEN_W,
  parameter int unsigned SEED  = 'h01,
  parameter int unsigned STEP  = 'h01,
  parameter int unsigned POLY  = 'hB8
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             start,
  input  logic [LEN_W-1:0] burst_len,
  input  logic             loop,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             busy,
  output logic             done
);

  localparam logic [WIDTH-1:0] SEED_W = WIDTH'(hs_seed_fix(hs_word_t'(SEED), WIDTH));

  hs_state_t        state_reg;
  logic [LEN_W-1:0] len_q_reg;
  logic [LEN_W-1:0] idx_reg;
  logic [WIDTH-1:0] data_reg;
  logic             done_reg;

  logic             accept;
  logic             last_beat;
  logic             start_ok;
  logic             load_seed;
  logic             advance;
  logic [WIDTH-1:0] payload;

  assign accept    = (state_reg == HS_SEND) && ready;
  assign last_beat = (idx_reg == len_q_reg - LEN_W'(1));
  assign start_ok  = (state_reg == HS_IDLE) && start && (burst_len != '0);
  assign load_seed = start_ok || (accept && last_beat && loop);
  assign advance   = accept && !last_beat;

  hs_pattern_gen #(
    .WIDTH (WIDTH),
    .SEED  (SEED),
    .STEP  (STEP),
    .POLY  (POLY)
  ) u_pattern_gen (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .load_seed (load_seed),
    .advance   (advance),
    .payload   (payload)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_reg <= HS_IDLE;
      len_q_reg <= '0;
      idx_reg   <= '0;
      data_reg  <= '0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        HS_IDLE: begin
          if (start) begin
            if (burst_len != '0) begin
              state_reg <= HS_SEND;
              len_q_reg <= burst_len;
              idx_reg   <= '0;
              data_reg  <= SEED_W;
            end else begin
              done_reg <= 1'b1;
            end
          end
        end
        HS_SEND: begin
          // Without ready nothing moves, which keeps data bit-exact under backpressure.
          if (ready) begin
            if (!last_beat) begin
              idx_reg  <= idx_reg + LEN_W'(1);
              data_reg <= payload;
            end else if (loop) begin
              idx_reg  <= '0;
              data_reg <= SEED_W;
            end else begin
              state_reg <= HS_IDLE;
              idx_reg   <= '0;
              done_reg  <= 1'b1;
            end
          end
        end
        default: state_reg <= HS_IDLE;
      endcase
    end
  end

  assign valid = (state_reg == HS_SEND);
  assign busy  = (state_reg == HS_SEND);
  assign data  = data_reg;
  assign done  = done_reg;

endmodule
